// File: rtl/seqdet_stream_ctrl.sv
// Stream controller for the bit-serial sequence detector: serializes handshaked words,
// programs pattern/length and counts hits. Define SEQDET_CTRL_LSB_FIRST_EN for LSB-first serialization.
module seqdet_stream_ctrl #(
  parameter int          DATA_W      = 8,
  parameter int          CNT_W       = 8,
  parameter logic [3:0]  RST_PATTERN = 4'b1011,
  parameter logic [2:0]  RST_LEN     = 3'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_pattern,
  input  logic [2:0]        cfg_len,
  output logic              cfg_err,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              det_bit,
  output logic              det_step,
  output logic              det_clear,
  input  logic              det_hit,
  output logic [3:0]        pat_out,
  output logic [2:0]        len_out,
  output logic              hit_pulse,
  output logic [CNT_W-1:0]  hit_count,
  input  logic              cnt_clr,
  output logic              busy
);

  localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         pat_q, pat_d;
  logic [2:0]         len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               samp_q, samp_d;
  logic               pulse_q, pulse_d;
  logic               err_q, err_d;

  logic is_idle, in_shift, last_bit, cfg_ok, accept, hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic len_legal(input logic [2:0] l);
    return (l != 3'd0) && (l <= 3'd4);
  endfunction

  assign is_idle  = (state_q == IDLE);
  assign in_shift = (state_q == SHIFT);
  assign last_bit = (idx_q == IDX_LAST);
  assign cfg_ok   = is_idle & len_legal(cfg_len);
  // A config strobe in IDLE owns the cycle, so the word waits.
  assign in_ready = ena & ((is_idle & ~cfg_we) | (in_shift & last_bit));
  assign accept   = in_valid & in_ready;
  assign hit      = samp_q & det_hit;

`ifdef SEQDET_CTRL_LSB_FIRST_EN
  assign det_bit  = in_shift & sreg_q[0];
`else
  assign det_bit  = in_shift & sreg_q[DATA_W-1];
`endif
  assign det_step  = ena & in_shift;
  assign det_clear = ena & (state_q == CLEAR);
  assign hit_pulse = ena & pulse_q;
  assign cfg_err   = ena & err_q;
  assign busy      = ~is_idle;
  assign pat_out   = pat_q;
  assign len_out   = len_q;
  assign hit_count = cnt_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    pulse_d = pulse_q;
    err_d   = err_q;
    if (ena) begin
      // Stage boundary: the step flag lines det_hit up one cycle after the detector advanced.
      samp_d  = in_shift;
      pulse_d = hit;
      err_d   = cfg_we & ~cfg_ok;
      if (cnt_clr)  cnt_d = '0;
      else if (hit) cnt_d = sat_inc(cnt_q);
      case (state_q)
        IDLE: begin
          if (cfg_we && cfg_ok) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            state_d = CLEAR;
          end
        end
        CLEAR: state_d = IDLE;
        SHIFT: begin
`ifdef SEQDET_CTRL_LSB_FIRST_EN
          sreg_d = sreg_q >> 1;
`else
          sreg_d = sreg_q << 1;
`endif
          idx_d = idx_q + 1'b1;
          if (last_bit) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        sreg_d  = in_data;
        idx_d   = '0;
        state_d = SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= RST_PATTERN;
      len_q   <= RST_LEN;
      cnt_q   <= '0;
      samp_q  <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  // Word data needs no reset: it is only observed while SHIFT, which requires a fresh load.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Bench for seqdet_stream_ctrl: directed scenarios plus randomized traffic, checked each cycle
// against a queue-based reference model; a behavioural detector closes the loop on det_hit.
module tb_seqdet_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, cfg_we, in_valid, cnt_clr, stray;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic [7:0] in_data;
  logic       det_hit, det_match;

  logic       cfg_err, in_ready, det_bit, det_step, det_clear, hit_pulse, busy;
  logic [3:0] pat_out;
  logic [2:0] len_out;
  logic [7:0] hit_count;

  logic       cfg_err2, in_ready2, det_bit2, det_step2, det_clear2, hit_pulse2, busy2;
  logic [3:0] pat_out2;
  logic [2:0] len_out2;
  logic [1:0] hit_count2;

  seqdet_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_err(cfg_err), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .det_bit(det_bit), .det_step(det_step), .det_clear(det_clear),
    .det_hit(det_hit), .pat_out(pat_out), .len_out(len_out), .hit_pulse(hit_pulse),
    .hit_count(hit_count), .cnt_clr(cnt_clr), .busy(busy)
  );

  seqdet_stream_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_err(cfg_err2), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .det_bit(det_bit2), .det_step(det_step2), .det_clear(det_clear2),
    .det_hit(det_hit), .pat_out(pat_out2), .len_out(len_out2), .hit_pulse(hit_pulse2),
    .hit_count(hit_count2), .cnt_clr(cnt_clr), .busy(busy2)
  );

  // Behavioural detector: history of stepped bits compared with the programmed pattern.
  logic [3:0] hist;
  int         dnb;
  int         dl;
  logic [3:0] dmask;
  always_ff @(posedge clk) begin
    if (!rst_n || det_clear) begin
      hist <= 4'd0;
      dnb  <= 0;
    end else if (det_step) begin
      hist <= {hist[2:0], det_bit};
      dnb  <= (dnb < 4) ? dnb + 1 : 4;
    end
  end
  always_comb begin
    dl        = int'(len_out);
    dmask     = 4'd0;
    det_match = 1'b0;
    if (dl >= 1 && dl <= 4) begin
      dmask     = 4'((1 << dl) - 1);
      det_match = (dnb >= dl) && ((hist & dmask) == ((pat_out >> (4 - dl)) & dmask));
    end
  end
  assign det_hit = det_match | stray;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: pending bits of the current word, a pending clear cycle, and counters.
  bit         mq[$];
  bit         m_clr = 0, m_samp = 0, m_pulse = 0, m_err = 0, started = 0;
  logic [3:0] m_pat = 4'b1011;
  logic [2:0] m_len = 3'd4;
  int         m_cnt = 0, m_cnt2 = 0;
  bit         mi_idle, mi_rdy, mi_hit, mi_ok;

  initial begin
    forever begin
      @(posedge clk);
      mi_idle = (mq.size() == 0) && !m_clr;
      if (!rst_n) begin
        mq.delete();
        m_clr = 0; m_samp = 0; m_pulse = 0; m_err = 0;
        m_pat = 4'b1011; m_len = 3'd4; m_cnt = 0; m_cnt2 = 0;
      end else if (ena) begin
        mi_rdy  = (mi_idle && !cfg_we) || (mq.size() == 1);
        mi_hit  = m_samp && det_hit;
        mi_ok   = mi_idle && cfg_len >= 3'd1 && cfg_len <= 3'd4;
        m_pulse = mi_hit;
        if (cnt_clr) begin
          m_cnt = 0; m_cnt2 = 0;
        end else if (mi_hit) begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        m_err  = cfg_we && !mi_ok;
        m_samp = (mq.size() > 0);
        if (mq.size() > 0) void'(mq.pop_front());
        m_clr = 0;
        if (cfg_we && mi_ok) begin
          m_pat = cfg_pattern; m_len = cfg_len; m_clr = 1;
        end
        if (in_valid && mi_rdy)
          for (int i = 7; i >= 0; i--) mq.push_back(in_data[i]);
      end
      started = 1;
    end
  end

  task automatic cmp_set(input string t, input logic b, input logic st, input logic bt,
                         input logic cl, input logic rd, input logic er, input logic pu,
                         input logic [3:0] pt, input logic [2:0] ln, input logic [31:0] cn,
                         input int ecnt);
    bit sh, idl;
    sh  = (mq.size() > 0);
    idl = !sh && !m_clr;
    chk({t, "_busy"},      b,  !idl);
    chk({t, "_det_step"},  st, ena && sh);
    chk({t, "_det_bit"},   bt, sh ? mq[0] : 1'b0);
    chk({t, "_det_clear"}, cl, ena && m_clr);
    chk({t, "_in_ready"},  rd, ena && ((idl && !cfg_we) || mq.size() == 1));
    chk({t, "_cfg_err"},   er, ena && m_err);
    chk({t, "_hit_pulse"}, pu, ena && m_pulse);
    chk({t, "_pat_out"},   pt, m_pat);
    chk({t, "_len_out"},   ln, m_len);
    chk({t, "_hit_count"}, cn, ecnt);
  endtask

  bit  cap[$];
  int  steps = 0, run = 0, max_run = 0, accepts = 0;
  int  h2q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        cmp_set("a", busy, det_step, det_bit, det_clear, in_ready, cfg_err, hit_pulse,
                pat_out, len_out, 32'(hit_count), m_cnt);
        cmp_set("b", busy2, det_step2, det_bit2, det_clear2, in_ready2, cfg_err2, hit_pulse2,
                pat_out2, len_out2, 32'(hit_count2), m_cnt2);
        if (det_step) begin
          cap.push_back(det_bit);
          steps++;
          run++;
          if (run > max_run) max_run = run;
        end else run = 0;
        if (in_valid && in_ready) accepts++;
        if (hit_pulse2) h2q.push_back(int'(hit_count2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit hold);
    bit done;
    done     = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    chk("send_accept", done, 1'b1);
    if (!hold) in_valid = 1'b0;
  endtask

  function automatic logic [15:0] cap_bits();
    logic [15:0] v;
    v = 16'd0;
    for (int i = 0; i < cap.size() && i < 16; i++) v = {v[14:0], cap[i]};
    return v;
  endfunction

  int  sat_exp [5] = '{1, 2, 3, 3, 3};
  bit  found;

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_pattern = 4'd0; cfg_len = 3'd0;
    in_data = 8'd0; in_valid = 1'b0; cnt_clr = 1'b0; stray = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pat", pat_out, 4'b1011);
    chk("rst_len", len_out, 3'd4);
    chk("rst_cnt", hit_count, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    tick();

    // Two words streamed back to back, MSB first.
    cap.delete();
    send_word(8'b0001_0110, 1);
    send_word(8'b0000_0000, 0);
    repeat (12) tick();
    chk("t1_nbits", cap.size(), 16);
    chk("t1_stream", cap_bits(), 16'b0001_0110_0000_0000);
    chk("t1_count", hit_count, 8'd1);

    cap.delete(); accepts = 0; max_run = 0; run = 0;
    send_word(8'hB6, 1);
    send_word(8'hB6, 0);
    repeat (12) tick();
    chk("t2_run", max_run, 16);
    chk("t2_accepts", accepts, 2);
    chk("t2_count", hit_count, 8'd5);

    cfg_pattern = 4'b0110; cfg_len = 3'd3; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("t3_pat", pat_out, 4'b0110);
    chk("t3_len", len_out, 3'd3);
    chk("t3_clear", det_clear, 1'b1);
    chk("t3_ready_clr", in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("t3_clear_end", det_clear, 1'b0);
    chk("t3_ready_back", in_ready, 1'b1);
    tick();
    send_word(8'hFF, 0);
    cfg_pattern = 4'b1011; cfg_len = 3'd4; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("t3_err_shift", cfg_err, 1'b1);
    chk("t3_pat_kept", pat_out, 4'b0110);
    tick();
    repeat (10) tick();
    cfg_len = 3'd0; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("t3_err_len0", cfg_err, 1'b1);
    chk("t3_len_kept", len_out, 3'd3);
    tick();
    cfg_pattern = 4'b1011; cfg_len = 3'd4; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();

    // Saturation in the 2-bit counter, then clear racing a hit.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    h2q.delete();
    for (int w = 0; w < 5; w++) send_word(8'b0001_0110, (w < 4));
    repeat (12) tick();
    chk("t4_npulses", h2q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t4_sat_seq", (i < h2q.size()) ? 32'(h2q[i]) : 32'hFFFF, sat_exp[i]);
    send_word(8'b0001_0110, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (det_hit) begin
        cnt_clr = 1'b1;
        found   = 1;
      end
    end
    chk("t4_hit_seen", found, 1'b1);
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("t4_clr_pulse", hit_pulse, 1'b1);
    chk("t4_clr_cnt", hit_count, 8'd0);
    chk("t4_clr_cnt2", hit_count2, 2'd0);
    tick();
    repeat (4) tick();

    // Enable dropped mid-word.
    cap.delete(); steps = 0;
    send_word(8'b0001_0110, 0);
    repeat (3) tick();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_frozen_step", det_step, 1'b0);
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    repeat (12) tick();
    chk("t5_steps", steps, 8);
    chk("t5_stream", cap_bits(), 16'h0016);

    // Reset in the middle of a word.
    cfg_pattern = 4'b0110; cfg_len = 3'd3; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    send_word(8'hFF, 0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    steps = 0;
    @(negedge clk);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_pat", pat_out, 4'b1011);
    chk("t6_cnt", hit_count, 8'd0);
    tick();
    repeat (10) tick();
    chk("t6_no_steps", steps, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      ena         = ($urandom_range(0, 9) != 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      cfg_we      = ($urandom_range(0, 24) == 0);
      cfg_pattern = 4'($urandom);
      cfg_len     = 3'($urandom);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 8'($urandom);
      cnt_clr     = ($urandom_range(0, 39) == 0);
      stray       = ($urandom_range(0, 7) == 0);
      tick();
    end
    ena = 1'b1; rst_n = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; stray = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
